// File: rtl/jt7759_rom_server.sv
// Byte-read server for the jt7759 sample-ROM port: a two-word cache in front of a
// 16-bit req/ack memory, with optional next-word prefetch to keep ADPCM streaming fed.
module jt7759_rom_server #(
  parameter bit PREFETCH = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_cs,
  input  logic [16:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        rom_ok,
  input  logic        flush,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_ack,
  output logic [1:0]  fsm_state
);

  // Memory handshake: mem_req rises with a stable mem_addr and stays high until the
  // cycle mem_ack is seen; it is low the following cycle. mem_ack with mem_req low is ignored.
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, PREF = 2'd2} state_t;

  state_t      state;
  logic [1:0]  valid;
  logic [15:0] tag  [2];
  logic [15:0] word [2];
  logic        lru;
  logic        target;
  logic        discard;
  logic [16:0] addr_q;

  logic [15:0] rom_word;
  logic [15:0] next_word;
  logic        hit0;
  logic        hit1;
  logic        hit;
  logic        hit_idx;
  logic [15:0] hit_word;
  logic        other_has_next;

  always_comb begin
    rom_word       = rom_addr[16:1];
    next_word      = rom_word + 16'd1;
    hit0           = valid[0] && (tag[0] == rom_word);
    hit1           = valid[1] && (tag[1] == rom_word);
    hit            = rom_cs && (hit0 || hit1);
    hit_idx        = hit1;
    hit_word       = hit1 ? word[1] : word[0];
    other_has_next = hit1 ? (valid[0] && (tag[0] == next_word))
                          : (valid[1] && (tag[1] == next_word));
  end

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= 2'b00;
      lru      <= 1'b0;
      target   <= 1'b0;
      discard  <= 1'b0;
      addr_q   <= 17'd0;
      rom_ok   <= 1'b0;
      rom_data <= 8'd0;
      mem_req  <= 1'b0;
      mem_addr <= 16'd0;
    end else begin
      addr_q <= rom_addr;
      // Requiring the address to match last cycle's keeps rom_ok from ever being stale.
      rom_ok <= hit && (rom_addr == addr_q) && !flush;
      if (hit) begin
        rom_data <= rom_addr[0] ? hit_word[15:8] : hit_word[7:0];
        lru      <= ~hit_idx;
      end

      case (state)
        IDLE: begin
          if (!flush) begin
            if (rom_cs && !hit) begin
              state    <= FILL;
              mem_req  <= 1'b1;
              mem_addr <= rom_word;
              target   <= lru;
            end else if (PREFETCH && hit && !other_has_next) begin
              state    <= PREF;
              mem_req  <= 1'b1;
              mem_addr <= next_word;
              target   <= ~hit_idx;
            end
          end
        end
        FILL, PREF: begin
          if (flush) discard <= 1'b1;
          if (!mem_req) begin
            mem_req <= 1'b1;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            discard <= 1'b0;
            // A flush seen at any point during the request poisons its data.
            if (!(discard || flush)) begin
              valid[target] <= 1'b1;
              tag[target]   <= mem_addr;
              word[target]  <= mem_data;
            end
            if (state == FILL && PREFETCH && !(discard || flush)) begin
              state    <= PREF;
              mem_addr <= mem_addr + 16'd1;
              target   <= ~target;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (flush) valid <= 2'b00;
    end
  end

endmodule
